status_vector_scheduler: RTL
============================

// Module: status_vector_scheduler
// PURPOSE
//   In-order allocation and retirement controller for a DEPTH-entry status-valid vector shared by NREQ requesters.
//   Round-robin arbitration picks one requester per cycle and allocates the tail slot; the requester gets the slot tag.
//   Completions update a slot's status value by tag. The oldest completed slot retires through a valid/ready port.
//   Sits between the requester agents and the retirement/commit logic.
// PARAMETERS
//   DEPTH  32  number of status slots; power of two, >= 2
//   NREQ   4   number of requesters; >= 2
//   TAG_W  $clog2(DEPTH)  local, derived; slot tag width
//   ID_W   $clog2(NREQ)   local, derived; requester id width
// PORTS
//   clk_i            in   1        clock, rising edge
//   rsn_i            in   1        asynchronous active-low reset
//   req_i            in   NREQ     per-requester allocation request (level)
//   gnt_o            out  NREQ     one-hot grant, combinational, same cycle as allocation
//   tag_o            out  TAG_W    slot allocated to granted requester (= tail), valid when |gnt_o
//   cmpl_i           in   1        completion strobe
//   cmpl_tag_i       in   TAG_W    slot being completed
//   cmpl_value_i     in   1        status value written into slot
//   retire_o         out  1        head slot is valid and done
//   retire_ready_i   in   1        consumer accepts retirement
//   retire_tag_o     out  TAG_W    head slot index
//   retire_id_o      out  ID_W     requester that owns head slot
//   retire_value_o   out  1        status value of head slot
//   full_o           out  1        count == DEPTH
//   empty_o          out  1        count == 0
//   count_o          out  TAG_W+1  occupied slots
//   err_o            out  1        sticky protocol error
// BEHAVIOUR
//   State: per slot {valid, done, value, owner[ID_W]}; head, tail (TAG_W, wrap DEPTH-1 -> 0); count; rr_ptr; err.
//   Reset (async, rsn_i low): all slots invalid, head=tail=0, count=0, rr_ptr=0, err=0.
//     Outputs in reset: gnt_o=0, retire_o=0, full_o=0, empty_o=1, count_o=0, err_o=0; tag/retire_* = 0.
//   Arbitration: if !full_o && |req_i, grant first set req_i[k] scanning k = rr_ptr, rr_ptr+1, ... mod NREQ.
//     On grant: slot[tail] <= {valid=1, done=0, value=0, owner=k}; tail++; rr_ptr <= (k+1) mod NREQ.
//     No grant: rr_ptr holds. full_o uses registered count; a same-cycle retire does not free a slot for allocation.
//   Completion: if cmpl_i && slot[cmpl_tag_i].valid && !done: done<=1, value<=cmpl_value_i.
//     cmpl_i to an invalid or already-done slot: slot unchanged, err<=1 (sticky until reset).
//     This includes a completion to the slot being allocated in the same cycle.
//   Retire: retire_o = slot[head].valid & slot[head].done (from registers, no bypass).
//     On retire_o && retire_ready_i: slot[head].valid<=0, head++.
//     retire_o stays high and retire_* stay stable until accepted.
//     Completion of the head slot in cycle N gives retire_o in cycle N+1.
//     Minimum latency is allocate@N, complete@N+1, retire_o@N+2.
//   count: +1 on grant only, -1 on retire only, unchanged on both; never exceeds DEPTH and never wraps below 0.
//   Out-of-order completions are held; retirement is strictly in allocation order.
//   Pointer wrap: tail==head with count==DEPTH means full; with count==0 it means empty.
//   Reset asserted mid-operation discards all slots; no retire is emitted for them.
// TESTING
//   1. Reset, req_i=4'b1111 for 4 cycles, with NREQ=4 -> gnt_o 0001,0010,0100,1000; tag_o 0,1,2,3; count_o=4.
//   2. Alloc tags 0,1 and complete tag1 with value=1, then tag0 with value=0 -> retire 0 (val 0), then 1 (val 1), in order.
//   3. Fill 32 slots -> full_o=1, gnt_o=0 with req high; retire one -> next cycle grant with tag_o=0 (wrap).
//   4. cmpl_i to free tag 5 -> err_o=1 and stays 1; a second completion to a done slot leaves its value unchanged.
//   5. retire_ready_i=0 for 3 cycles with head done -> retire_o held with stable retire_tag/id/value; count unchanged.
//   6. Assert rsn_i mid-traffic with count 7 -> all outputs at reset values immediately; first grant after release gets tag 0.

Source files
------------

// File: rtl/status_vector_scheduler.sv
// Purpose : in-order slot allocator / retirer over a DEPTH-entry status-valid vector, NREQ round-robin requesters.
// Latency : grant and tag combinational in the allocating cycle; slot completed in cycle N can retire in N+1 (alloc->retire min 2).
// Backpr. : no grant while full (registered count); retire_o and retire_* hold until retire_ready_i accepts.
//
// Ports:
//   clk_i / rsn_i                  clock (rising edge) / asynchronous active-low reset
//   req_i[NREQ]  -> gnt_o[NREQ]    level requests, one-hot grant; tag_o is the allocated slot (tail)
//   cmpl_i, cmpl_tag_i, cmpl_value_i   completion strobe writing the status value of a slot
//   retire_o / retire_ready_i      head slot valid and done / consumer accept
//   retire_tag_o, retire_id_o, retire_value_o   head slot index, owner and status value
//   full_o, empty_o, count_o       occupancy
//   err_o                          sticky: completion hit an invalid or already-done slot
module status_vector_scheduler #(
    parameter int DEPTH = 32,
    parameter int NREQ  = 4,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic [NREQ-1:0]   req_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [TAG_W-1:0]  tag_o,
    input  logic              cmpl_i,
    input  logic [TAG_W-1:0]  cmpl_tag_i,
    input  logic              cmpl_value_i,
    output logic              retire_o,
    input  logic              retire_ready_i,
    output logic [TAG_W-1:0]  retire_tag_o,
    output logic [ID_W-1:0]   retire_id_o,
    output logic              retire_value_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [TAG_W:0]    count_o,
    output logic              err_o
);

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            value;
        logic [ID_W-1:0] owner;
    } slot_t;

    slot_t            slots [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic [ID_W-1:0]  rr_ptr;
    logic             err;

    logic             full;
    logic             alloc;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W:0]    idx;
    logic             retire_fire;
    logic             cmpl_hit;
    logic [ID_W-1:0]  rr_next;

    assign full  = (count == (TAG_W+1)'(DEPTH));

    // Round-robin scan starting at rr_ptr. The sum is one bit wider than an id
    // so the modulo-NREQ wrap works for non-power-of-two NREQ as well.
    // Grants are gated by rsn_i so nothing is offered while reset is asserted.
    always_comb begin
        gnt_o  = '0;
        gnt_id = '0;
        alloc  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NREQ)) begin
                idx = idx - (ID_W+1)'(NREQ);
            end
            if (!alloc && rsn_i && !full && req_i[idx[ID_W-1:0]]) begin
                alloc                    = 1'b1;
                gnt_id                   = idx[ID_W-1:0];
                gnt_o[idx[ID_W-1:0]]     = 1'b1;
            end
        end
    end

    assign rr_next = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;

    // A slot being allocated this cycle is still invalid in the registers, so
    // a completion aimed at it lands in the error branch.
    assign cmpl_hit    = slots[cmpl_tag_i].valid && !slots[cmpl_tag_i].done;
    assign retire_o    = slots[head].valid && slots[head].done;
    assign retire_fire = retire_o && retire_ready_i;

    // Allocation (tail), completion (valid, not-done slot) and retirement
    // (valid, done head) can never address the same slot in one cycle, so the
    // writes below do not collide.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (alloc) begin
                slots[tail].valid <= 1'b1;
                slots[tail].done  <= 1'b0;
                slots[tail].value <= 1'b0;
                slots[tail].owner <= gnt_id;
                tail              <= tail + 1'b1;
                rr_ptr            <= rr_next;
            end
            if (cmpl_i) begin
                if (cmpl_hit) begin
                    slots[cmpl_tag_i].done  <= 1'b1;
                    slots[cmpl_tag_i].value <= cmpl_value_i;
                end else begin
                    err <= 1'b1;
                end
            end
            if (retire_fire) begin
                slots[head].valid <= 1'b0;
                head              <= head + 1'b1;
            end
            unique case ({alloc, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign tag_o          = tail;
    assign retire_tag_o   = head;
    assign retire_id_o    = slots[head].owner;
    assign retire_value_o = slots[head].value;
    assign full_o         = full;
    assign empty_o        = (count == '0);
    assign count_o        = count;
    assign err_o          = err;

endmodule
